// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared encodings for the register-file writeback arbiter: requester ids and stage states.
package regfile_wb_arbiter_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer only moves when both sides contend and a grant is issued.
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       Clk_i,
  input  logic       Rst_i,
  input  logic       En_i,
  input  logic [1:0] Req_i,
  output logic [1:0] Gnt_o
);

  req_id_e prio_q;
  req_id_e prio_d;

  // Bit 0 of Req_i/Gnt_o is requester A, bit 1 is requester B.
  always_comb begin
    Gnt_o  = 2'b00;
    prio_d = prio_q;
    if (En_i) begin
      unique case (Req_i)
        2'b01: Gnt_o = 2'b01;
        2'b10: Gnt_o = 2'b10;
        2'b11: begin
          Gnt_o  = (prio_q == REQ_A) ? 2'b01 : 2'b10;
          prio_d = other_req(prio_q);
        end
        default: Gnt_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      prio_q <= REQ_A;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load-unit writebacks into one register-file write port through a one-entry stage.
// Optional forwarding port is compiled in when RF_WB_FWD_EN is defined.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int  REG_WIDTH  = 32,
  parameter int  NUM_REGS   = 32,
  parameter bit  R0_IS_ZERO = 1'b1,
  localparam int SEL_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                 Clk_i,
  input  logic                 Rst_i,
  input  logic                 A_Valid_i,
  input  logic [SEL_W-1:0]     A_Rd_Sel_i,
  input  logic [REG_WIDTH-1:0] A_Data_i,
  output logic                 A_Ready_o,
  input  logic                 B_Valid_i,
  input  logic [SEL_W-1:0]     B_Rd_Sel_i,
  input  logic [REG_WIDTH-1:0] B_Data_i,
  output logic                 B_Ready_o,
  input  logic                 Rf_Hold_i,
  output logic                 Data_We_o,
  output logic [SEL_W-1:0]     Rd_Sel_o,
  output logic [REG_WIDTH-1:0] Data_o,
  output logic                 Busy_o
`ifdef RF_WB_FWD_EN
  ,
  input  logic [SEL_W-1:0]     Fwd_Sel_i,
  output logic                 Fwd_Hit_o,
  output logic [REG_WIDTH-1:0] Fwd_Data_o
`endif
);

  stage_state_e         state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [REG_WIDTH-1:0] data_q, data_d;

  logic                 stage_valid;
  logic                 drain;
  logic                 accept_en;
  logic [1:0]           gnt;
  logic [SEL_W-1:0]     grant_sel;
  logic [REG_WIDTH-1:0] grant_data;
  logic                 discard;
  logic                 load;

  assign stage_valid = (state_q == ST_FULL);
  assign drain       = stage_valid & ~Rf_Hold_i;
  // The stage can take a new entry if it is empty or is being written out this cycle.
  assign accept_en   = (~stage_valid | ~Rf_Hold_i) & ~Rst_i;

  rr_arbiter2 u_rr (
    .Clk_i (Clk_i),
    .Rst_i (Rst_i),
    .En_i  (accept_en),
    .Req_i ({B_Valid_i, A_Valid_i}),
    .Gnt_o (gnt)
  );

  assign A_Ready_o  = gnt[REQ_A];
  assign B_Ready_o  = gnt[REQ_B];
  assign grant_sel  = gnt[REQ_B] ? B_Rd_Sel_i : A_Rd_Sel_i;
  assign grant_data = gnt[REQ_B] ? B_Data_i : A_Data_i;
  // Writes to r0 are acknowledged but never reach the register file.
  assign discard    = R0_IS_ZERO && (grant_sel == '0);
  assign load       = (|gnt) && !discard;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (load) begin
          state_d = ST_FULL;
          sel_d   = grant_sel;
          data_d  = grant_data;
        end
      end
      ST_FULL: begin
        if (load) begin
          sel_d  = grant_sel;
          data_d = grant_data;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state_q <= ST_EMPTY;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign Data_We_o = drain;
  assign Rd_Sel_o  = sel_q;
  assign Data_o    = data_q;
  assign Busy_o    = stage_valid;

`ifdef RF_WB_FWD_EN
  assign Fwd_Hit_o  = stage_valid && (sel_q == Fwd_Sel_i) && !(R0_IS_ZERO && (Fwd_Sel_i == '0));
  assign Fwd_Data_o = data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then random traffic vs a queue model.
module tb_regfile_wb_arbiter;

  localparam int RW = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          Rst_i = 1'b0;
  logic          A_Valid_i = 1'b0;
  logic [SW-1:0] A_Rd_Sel_i = '0;
  logic [RW-1:0] A_Data_i = '0;
  logic          A_Ready_o;
  logic          B_Valid_i = 1'b0;
  logic [SW-1:0] B_Rd_Sel_i = '0;
  logic [RW-1:0] B_Data_i = '0;
  logic          B_Ready_o;
  logic          Rf_Hold_i = 1'b0;
  logic          Data_We_o;
  logic [SW-1:0] Rd_Sel_o;
  logic [RW-1:0] Data_o;
  logic          Busy_o;
`ifdef RF_WB_FWD_EN
  logic [SW-1:0] Fwd_Sel_i = '0;
  logic          Fwd_Hit_o;
  logic [RW-1:0] Fwd_Data_o;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.REG_WIDTH(RW), .NUM_REGS(32), .R0_IS_ZERO(1'b1)) dut (
    .Clk_i      (clk),
    .Rst_i      (Rst_i),
    .A_Valid_i  (A_Valid_i),
    .A_Rd_Sel_i (A_Rd_Sel_i),
    .A_Data_i   (A_Data_i),
    .A_Ready_o  (A_Ready_o),
    .B_Valid_i  (B_Valid_i),
    .B_Rd_Sel_i (B_Rd_Sel_i),
    .B_Data_i   (B_Data_i),
    .B_Ready_o  (B_Ready_o),
    .Rf_Hold_i  (Rf_Hold_i),
    .Data_We_o  (Data_We_o),
    .Rd_Sel_o   (Rd_Sel_o),
    .Data_o     (Data_o),
    .Busy_o     (Busy_o)
`ifdef RF_WB_FWD_EN
    ,
    .Fwd_Sel_i  (Fwd_Sel_i),
    .Fwd_Hit_o  (Fwd_Hit_o),
    .Fwd_Data_o (Fwd_Data_o)
`endif
  );

  // Model: accepted non-r0 writes queue up and leave in acceptance order;
  // tie_turn names who wins the next contested cycle (0 = A, 1 = B).
  typedef struct {
    logic [SW-1:0] sel;
    logic [RW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tie_turn = 0;
  int  n_pass = 0;
  int  n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, then advance the model at the rising edge.
  task automatic cycle(input logic av, input logic [SW-1:0] as, input logic [RW-1:0] ad,
                       input logic bv, input logic [SW-1:0] bs, input logic [RW-1:0] bd,
                       input logic hold);
    int   win;
    logic writes;
    @(negedge clk);
    A_Valid_i = av; A_Rd_Sel_i = as; A_Data_i = ad;
    B_Valid_i = bv; B_Rd_Sel_i = bs; B_Data_i = bd;
    Rf_Hold_i = hold;
    #1;
    writes = (exp_q.size() != 0) && !hold;
    win = -1;
    if (exp_q.size() == 0 || !hold) begin
      if (av && bv) win = tie_turn;
      else if (av) win = 0;
      else if (bv) win = 1;
    end
    check("a_ready", 64'(A_Ready_o), 64'(win == 0));
    check("b_ready", 64'(B_Ready_o), 64'(win == 1));
    check("data_we", 64'(Data_We_o), 64'(writes));
    check("busy", 64'(Busy_o), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("rd_sel", 64'(Rd_Sel_o), 64'(exp_q[0].sel));
      check("data", 64'(Data_o), 64'(exp_q[0].data));
    end
    @(posedge clk);
    if (writes) void'(exp_q.pop_front());
    if (av && bv && win >= 0) tie_turn = 1 - tie_turn;
    if (win == 0 && as != '0) exp_q.push_back('{sel: as, data: ad});
    if (win == 1 && bs != '0) exp_q.push_back('{sel: bs, data: bd});
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Reset raised mid-cycle: outputs must drop at once, whatever the stage held.
  task automatic do_reset();
    @(negedge clk);
    A_Valid_i = 1'b0; B_Valid_i = 1'b0; Rf_Hold_i = 1'b0;
    #1;
    Rst_i = 1'b1;
    A_Valid_i = 1'b1; B_Valid_i = 1'b1;
    A_Rd_Sel_i = 5'd3; B_Rd_Sel_i = 5'd4;
    #1;
    check("rst_busy", 64'(Busy_o), 64'(0));
    check("rst_we", 64'(Data_We_o), 64'(0));
    check("rst_a_ready", 64'(A_Ready_o), 64'(0));
    check("rst_b_ready", 64'(B_Ready_o), 64'(0));
    check("rst_rd_sel", 64'(Rd_Sel_o), 64'(0));
    check("rst_data", 64'(Data_o), 64'(0));
    exp_q.delete();
    tie_turn = 0;
    A_Valid_i = 1'b0; B_Valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 Rst_i = 1'b0;
  endtask

  initial begin
    logic          av, bv, hold;
    logic [SW-1:0] as, bs;
    logic [RW-1:0] ad, bd;

    do_reset();

    // Single requester A: accepted now, written one cycle later.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
    idle();
    idle();

    // Both requesters contend for four cycles straight after reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 5'(1 + i), 32'hA0 + 32'(i), 1'b1, 5'(10 + i), 32'hB0 + 32'(i), 1'b0);
    end
    idle();
    idle();

    // Full stage held for three cycles, then released with a fresh request waiting.
    cycle(1'b1, 5'd3, 32'h33, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b1);
    end
    cycle(1'b0, '0, '0, 1'b1, 5'd6, 32'h66, 1'b0);
    idle();
    idle();

    // Write to r0 is acknowledged and dropped.
    cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 1'b0);
    idle();

    // Reset with a pending entry, then contention must favour A again.
    cycle(1'b1, 5'd9, 32'hCAFE, 1'b0, '0, '0, 1'b0);
    do_reset();
    cycle(1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33, 1'b0);
    idle();
    idle();

`ifdef RF_WB_FWD_EN
    cycle(1'b1, 5'd7, 32'h55, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    A_Valid_i = 1'b0; B_Valid_i = 1'b0; Rf_Hold_i = 1'b1;
    Fwd_Sel_i = 5'd7;
    #1;
    check("fwd_hit7", 64'(Fwd_Hit_o), 64'(1));
    check("fwd_data7", 64'(Fwd_Data_o), 64'h55);
    Fwd_Sel_i = 5'd6;
    #1;
    check("fwd_hit6", 64'(Fwd_Hit_o), 64'(0));
    idle();
    idle();
`endif

    // Random traffic with occasional r0 targets and back-pressure.
    for (int n = 0; n < 400; n++) begin
      av   = ($urandom_range(0, 99) < 60);
      bv   = ($urandom_range(0, 99) < 60);
      hold = ($urandom_range(0, 99) < 25);
      as   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bs   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ad   = $urandom;
      bd   = $urandom;
      cycle(av, as, ad, bv, bs, bd, hold);
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
